// File: rtl/usr_types_and_params.sv
// Shared widths, per-input array types and FSM encoding for the stream mux.
package usr_types_and_params;

    localparam int unsigned DATA_WIDTH    = 64;
    localparam int unsigned CHANNEL_WIDTH = 10;
    localparam int unsigned EMPTY_WIDTH   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned RX_DIR        = 4;
    localparam int unsigned DIR_SEL_WIDTH = (RX_DIR == 1) ? 1 : $clog2(RX_DIR);

    typedef logic [DATA_WIDTH-1:0]    data_t;
    typedef logic [CHANNEL_WIDTH-1:0] channel_t;
    typedef logic [EMPTY_WIDTH-1:0]   empty_t;
    typedef logic [DIR_SEL_WIDTH-1:0] dir_t;

    // Per-input bundles, index = source input number.
    typedef data_t    [RX_DIR-1:0] data_arr_t;
    typedef empty_t   [RX_DIR-1:0] empty_arr_t;
    typedef channel_t [RX_DIR-1:0] channel_arr_t;
    typedef logic     [RX_DIR-1:0] dir_vec_t;

    typedef enum logic [0:0] {StIdle, StPkt} mux_state_e;

    // Next round-robin start point after serving input d, wrapping at RX_DIR.
    function automatic dir_t next_dir(input dir_t d);
        if (32'(d) == RX_DIR - 1) return '0;
        return d + 1'b1;
    endfunction

endpackage

// File: rtl/ast_mux_if.sv
// Bundle of the RX_DIR input streams and the merged output stream.
interface ast_mux_if
    import usr_types_and_params::*;
;
    data_arr_t    ast_data_i;
    dir_vec_t     ast_startofpacket_i;
    dir_vec_t     ast_endofpacket_i;
    dir_vec_t     ast_valid_i;
    empty_arr_t   ast_empty_i;
    channel_arr_t ast_channel_i;
    dir_vec_t     ast_ready_o;

    data_t        ast_data_o;
    logic         ast_startofpacket_o;
    logic         ast_endofpacket_o;
    logic         ast_valid_o;
    empty_t       ast_empty_o;
    channel_t     ast_channel_o;
    dir_t         ast_dir_o;
    logic         ast_ready_i;

    // The mux side.
    modport slave (
        input  ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
        input  ast_empty_i, ast_channel_i, ast_ready_i,
        output ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
        output ast_valid_o, ast_empty_o, ast_channel_o, ast_dir_o
    );

    // The sources/sink side.
    modport master (
        output ast_data_i, ast_startofpacket_i, ast_endofpacket_i, ast_valid_i,
        output ast_empty_i, ast_channel_i, ast_ready_i,
        input  ast_ready_o, ast_data_o, ast_startofpacket_o, ast_endofpacket_o,
        input  ast_valid_o, ast_empty_o, ast_channel_o, ast_dir_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at rr_ptr, rr_ptr+1, ... mod RX_DIR.
module rr_arbiter
    import usr_types_and_params::*;
(
    input  dir_vec_t req,
    input  dir_t     rr_ptr,
    output dir_t     grant,
    output logic     any_req
);

    int unsigned idx;
    dir_t        sel;

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        grant   = '0;
        any_req = |req;
        idx     = 0;
        sel     = '0;
        for (int unsigned off = RX_DIR; off > 0; off--) begin
            idx = (32'(rr_ptr) + off - 1) % RX_DIR;
            sel = dir_t'(idx);
            if (req[sel]) grant = sel;
        end
    end

endmodule

// File: rtl/ast_mux.sv
// Packet-aware N:1 Avalon-ST mux; grant held SOP..EOP, output beats tagged with source index.
module ast_mux
    import usr_types_and_params::*;
(
    input  logic      clk_i,
    input  logic      rst_n_i,
    ast_mux_if.slave  bus
);

    mux_state_e state_q;
    dir_t       grant_q;
    dir_t       rr_ptr_q;
    dir_t       arb_grant;
    logic       arb_any;
    logic       out_free;
    logic       accept;

    rr_arbiter u_arb (
        .req     (bus.ast_valid_i),
        .rr_ptr  (rr_ptr_q),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

    // Only the granted input sees ready, and only when the output register can take a beat.
    always_comb begin
        out_free        = !bus.ast_valid_o || bus.ast_ready_i;
        bus.ast_ready_o = '0;
        if (state_q == StPkt) bus.ast_ready_o[grant_q] = out_free;
        accept = bus.ast_valid_i[grant_q] && bus.ast_ready_o[grant_q];
    end

    // Arbitration FSM plus the single-stage output register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q                 <= StIdle;
            grant_q                 <= '0;
            rr_ptr_q                <= '0;
            bus.ast_valid_o         <= 1'b0;
            bus.ast_data_o          <= '0;
            bus.ast_startofpacket_o <= 1'b0;
            bus.ast_endofpacket_o   <= 1'b0;
            bus.ast_empty_o         <= '0;
            bus.ast_channel_o       <= '0;
            bus.ast_dir_o           <= '0;
        end else begin
            // A load wins over a pop so back-to-back beats keep valid high.
            if (accept) begin
                bus.ast_valid_o         <= 1'b1;
                bus.ast_data_o          <= bus.ast_data_i[grant_q];
                bus.ast_startofpacket_o <= bus.ast_startofpacket_i[grant_q];
                bus.ast_endofpacket_o   <= bus.ast_endofpacket_i[grant_q];
                bus.ast_empty_o         <= bus.ast_empty_i[grant_q];
                bus.ast_channel_o       <= bus.ast_channel_i[grant_q];
                bus.ast_dir_o           <= grant_q;
            end else if (bus.ast_valid_o && bus.ast_ready_i) begin
                bus.ast_valid_o <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (arb_any) begin
                        grant_q <= arb_grant;
                        state_q <= StPkt;
                    end
                end
                StPkt: begin
                    if (accept && bus.ast_endofpacket_i[grant_q]) begin
                        rr_ptr_q <= next_dir(grant_q);
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ast_mux.sv
// Directed bench for ast_mux: reactive per-input sources, expected beats queued in arbitration order.
module tb_ast_mux;
    import usr_types_and_params::*;

    typedef struct {
        data_t    data;
        logic     sop;
        logic     eop;
        empty_t   empty;
        channel_t ch;
        dir_t     dir;
        int       gap;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;

    ast_mux_if bus ();

    ast_mux dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    beat_t exp_q[$];
    beat_t src_q[RX_DIR][$];
    int    wait_cnt[RX_DIR];
    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    first_v     = -1;
    int    last_v      = -1;
    int    first_r     = -1;
    logic  toggle_rdy  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_valid"}, 64'(bus.ast_valid_o), 64'd0);
        chk({pfx, "_data"}, 64'(bus.ast_data_o), 64'd0);
        chk({pfx, "_sop"}, 64'(bus.ast_startofpacket_o), 64'd0);
        chk({pfx, "_eop"}, 64'(bus.ast_endofpacket_o), 64'd0);
        chk({pfx, "_empty"}, 64'(bus.ast_empty_o), 64'd0);
        chk({pfx, "_channel"}, 64'(bus.ast_channel_o), 64'd0);
        chk({pfx, "_dir"}, 64'(bus.ast_dir_o), 64'd0);
        chk({pfx, "_ready_o"}, 64'(bus.ast_ready_o), 64'd0);
    endtask

    task automatic drive(input int i);
        beat_t b;
        dir_t  d;
        b = src_q[i][0];
        d = dir_t'(i);
        bus.ast_data_i[d]          = b.data;
        bus.ast_startofpacket_i[d] = b.sop;
        bus.ast_endofpacket_i[d]   = b.eop;
        bus.ast_empty_i[d]         = b.empty;
        bus.ast_channel_i[d]       = b.ch;
        bus.ast_valid_i[d]         = 1'b1;
    endtask

    task automatic present(input int i);
        dir_t d;
        d = dir_t'(i);
        if (src_q[i].size() == 0) begin
            bus.ast_valid_i[d] = 1'b0;
        end else if (src_q[i][0].gap > 0) begin
            bus.ast_valid_i[d] = 1'b0;
            wait_cnt[i]        = src_q[i][0].gap;
        end else begin
            drive(i);
        end
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < int'(RX_DIR); i++) n += src_q[i].size();
        return n;
    endfunction

    // One clock: check the output at the falling edge, then advance the sources after the rise.
    task automatic tick();
        logic [RX_DIR-1:0] acc;
        beat_t             e;
        @(negedge clk);
        cyc++;
        acc = bus.ast_valid_i & bus.ast_ready_o;
        if (rst_n) begin
            if (bus.ast_ready_o != '0 && first_r < 0) first_r = cyc;
            if (bus.ast_valid_o) begin
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q[0];
                    chk("data", 64'(bus.ast_data_o), 64'(e.data));
                    chk("sop", 64'(bus.ast_startofpacket_o), 64'(e.sop));
                    chk("eop", 64'(bus.ast_endofpacket_o), 64'(e.eop));
                    chk("empty", 64'(bus.ast_empty_o), 64'(e.empty));
                    chk("channel", 64'(bus.ast_channel_o), 64'(e.ch));
                    chk("dir", 64'(bus.ast_dir_o), 64'(e.dir));
                    if (bus.ast_ready_i) void'(exp_q.pop_front());
                end
                if (!bus.ast_ready_i) chk("stall_ready_o", 64'(bus.ast_ready_o), 64'd0);
            end
        end
        @(posedge clk);
        #1;
        if (toggle_rdy) bus.ast_ready_i = !bus.ast_ready_i;
        for (int i = 0; i < int'(RX_DIR); i++) begin
            if (acc[dir_t'(i)]) begin
                void'(src_q[i].pop_front());
                present(i);
            end else if (wait_cnt[i] > 0) begin
                wait_cnt[i]--;
                if (wait_cnt[i] == 0) drive(i);
            end
        end
    endtask

    task automatic send_pkt(input int src, input int n, input data_t base, input channel_t ch,
                            input empty_t e, input int gap_idx, input int gap);
        beat_t b;
        bit    was_idle;
        was_idle = (src_q[src].size() == 0) && (wait_cnt[src] == 0);
        for (int k = 0; k < n; k++) begin
            b.data  = base * data_t'(k + 1);
            b.sop   = (k == 0);
            b.eop   = (k == n - 1);
            b.empty = b.eop ? e : '0;
            b.ch    = ch;
            b.dir   = dir_t'(src);
            b.gap   = (k == gap_idx) ? gap : 0;
            src_q[src].push_back(b);
            exp_q.push_back(b);
        end
        if (was_idle) present(src);
    endtask

    task automatic wait_idle(input int maxc, input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || pending() != 0) && n < maxc) begin
            tick();
            n++;
        end
        chk({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        toggle_rdy      = 1'b0;
        bus.ast_ready_i = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                   = 1'b0;
        bus.ast_valid_i         = '0;
        bus.ast_data_i          = '0;
        bus.ast_startofpacket_i = '0;
        bus.ast_endofpacket_i   = '0;
        bus.ast_empty_i         = '0;
        bus.ast_channel_i       = '0;
        bus.ast_ready_i         = 1'b0;
        for (int i = 0; i < int'(RX_DIR); i++) wait_cnt[i] = 0;
        #12;
        chk_outputs_zero("reset");

        // All inputs hold a 2-beat packet out of reset; input 0 queues a second one.
        bus.ast_ready_i = 1'b1;
        send_pkt(0, 2, 64'h0A00, 10'd1, 3'd1, -1, 0);
        send_pkt(1, 2, 64'h0B00, 10'd2, 3'd2, -1, 0);
        send_pkt(2, 2, 64'h0C00, 10'd3, 3'd3, -1, 0);
        send_pkt(3, 2, 64'h0D00, 10'd4, 3'd4, -1, 0);
        send_pkt(0, 2, 64'h0E00, 10'd6, 3'd6, -1, 0);
        first_v = -1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_idle(80, "t2");
        chk("t2_span_one_bubble_per_pkt", 64'(last_v - first_v), 64'd13);

        // Input 2, 3-beat packet, sink always ready.
        first_v = -1;
        first_r = -1;
        send_pkt(2, 3, 64'h11, 10'd5, 3'd3, -1, 0);
        wait_idle(30, "t1");
        chk("t1_first_beat_latency", 64'(first_v - first_r), 64'd1);
        chk("t1_back_to_back", 64'(last_v - first_v), 64'd2);

        // Input 1, 4 beats under a toggling sink ready.
        send_pkt(1, 4, 64'h4000_0001, 10'd7, 3'd5, -1, 0);
        toggle_rdy = 1'b1;
        wait_idle(40, "t3");

        // Single-beat packets on 3 and 0 alternate, pointer wrapping 3 -> 0.
        send_pkt(3, 1, 64'hA3, 10'd11, 3'd7, -1, 0);
        send_pkt(0, 1, 64'hB0, 10'd12, 3'd0, -1, 0);
        send_pkt(3, 1, 64'hC3, 10'd13, 3'd2, -1, 0);
        send_pkt(0, 1, 64'hD0, 10'd14, 3'd4, -1, 0);
        wait_idle(30, "t4");

        // Input 0 stalls 2 cycles mid-packet; input 1 must wait for its EOP.
        send_pkt(0, 4, 64'h5000, 10'd21, 3'd1, 2, 2);
        tick();
        tick();
        send_pkt(1, 2, 64'h5100, 10'd22, 3'd2, -1, 0);
        for (int n = 0; n < 20 && src_q[0].size() != 0; n++) begin
            chk("t5_no_grant_to_1", 64'(bus.ast_ready_o[1]), 64'd0);
            tick();
        end
        chk("t5_input0_done", 64'(src_q[0].size()), 64'd0);
        wait_idle(30, "t5");

        // Asynchronous reset in the middle of a packet from input 2.
        send_pkt(2, 4, 64'h6000, 10'd9, 3'd1, -1, 0);
        tick();
        tick();
        tick();
        chk("t6_valid_before_reset", 64'(bus.ast_valid_o), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk_outputs_zero("t6_async_reset");
        exp_q.delete();
        for (int i = 0; i < int'(RX_DIR); i++) begin
            src_q[i].delete();
            wait_cnt[i] = 0;
        end
        bus.ast_valid_i = '0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        send_pkt(2, 2, 64'h7000, 10'd15, 3'd6, -1, 0);
        wait_idle(30, "t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ast_mux.md
Name: ast_mux

Overview:
- Packet-aware N:1 Avalon-ST multiplexer; inverse of the stream demux.
- Merges RX_DIR input streams into one output stream.
- Arbitrates round-robin on packet boundaries and holds the grant from startofpacket to endofpacket.
- Tags each output beat with the source index, so a downstream demux can route it back.

Parameters:
- DATA_WIDTH, 64, data bus width in bits.
- CHANNEL_WIDTH, 10, channel field width.
- EMPTY_WIDTH, $clog2(DATA_WIDTH/8), empty field width.
- RX_DIR, 4, number of input streams (>=1).
- DIR_SEL_WIDTH, RX_DIR==1 ? 1 : $clog2(RX_DIR), source index width.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_n_i  in  1  asynchronous active-low reset.
- ast_data_i  in  RX_DIR x DATA_WIDTH  per-input data.
- ast_startofpacket_i  in  RX_DIR  per-input SOP.
- ast_endofpacket_i  in  RX_DIR  per-input EOP.
- ast_valid_i  in  RX_DIR  per-input valid.
- ast_empty_i  in  RX_DIR x EMPTY_WIDTH  per-input empty bytes; meaningful on EOP only.
- ast_channel_i  in  RX_DIR x CHANNEL_WIDTH  per-input channel.
- ast_ready_o  out  RX_DIR  per-input ready.
- ast_data_o  out  DATA_WIDTH  merged data.
- ast_startofpacket_o  out  1  merged SOP.
- ast_endofpacket_o  out  1  merged EOP.
- ast_valid_o  out  1  merged valid.
- ast_empty_o  out  EMPTY_WIDTH  merged empty.
- ast_channel_o  out  CHANNEL_WIDTH  merged channel.
- ast_dir_o  out  DIR_SEL_WIDTH  index of the source input of the current beat.
- ast_ready_i  in  1  downstream ready.

Behaviour:
- Reset (rst_n_i low, asynchronous): all outputs 0, ast_ready_o = 0, FSM = IDLE, rr_ptr = 0. Any packet in flight is dropped with no EOP emitted. Operation resumes on the first rising edge after deassertion.
- FSM states: IDLE, PKT.
- IDLE:
  - ast_ready_o = 0.
  - If any ast_valid_i is set, grant the first valid input searching rr_ptr, rr_ptr+1, ... modulo RX_DIR. Register grant; go to PKT.
  - Arbitration costs exactly 1 bubble cycle per packet.
- PKT:
  - ast_ready_o[grant] = !ast_valid_o || ast_ready_i.
  - All other ready bits are 0.
  - Input beat accepted = ast_valid_i[grant] && ast_ready_o[grant].
- On an accepted beat:
  - Output register loads data/sop/eop/empty/channel from input `grant`.
  - ast_dir_o loads `grant`; ast_valid_o = 1 next cycle. Latency is 1 cycle.
- Accepted beat with EOP:
  - rr_ptr = (grant+1) mod RX_DIR; go to IDLE.
  - Wrap: grant RX_DIR-1 gives rr_ptr 0.
- Output register, no new input beat:
  - If ast_valid_o && ast_ready_i, clear ast_valid_o.
  - Data fields hold their last values; they are don't-care while valid is 0.
- Backpressure: while ast_valid_o && !ast_ready_i, the output register holds stable and ast_ready_o[grant] = 0.
- Simultaneous output-pop and input-accept in the same cycle: the register reloads and ast_valid_o stays 1. Full throughput is 1 beat/cycle within a packet.
- Granted input drops valid mid-packet: the grant is held and no other input is served until EOP.
- Single-beat packet (SOP & EOP in one beat): granted, passed, and released in the same accept cycle.
- Inputs without SOP at grant are passed unchanged; the block does no protocol checking.
- RX_DIR = 1: grant is always 0 and ast_dir_o = 0; the IDLE bubble still applies.

Decomposition:
- Shared package usr_types_and_params gains:
  - RX_DIR
  - DIR_SEL_WIDTH, derived from RX_DIR
  - the typedef for the per-input arrays
- DATA_WIDTH, CHANNEL_WIDTH and EMPTY_WIDTH are reused from that package.
- One sub-module, rr_arbiter: combinational round-robin select over a request vector, given rr_ptr. Outputs grant index and any_req.
- FSM and output register stay in ast_mux.

Test Plan:
- Input 2 sends a 3-beat packet (data 0x11, 0x22, 0x33; channel 5; empty 3 on EOP), ast_ready_i=1 -> output beats 0x11/0x22/0x33 appear on consecutive cycles with ast_dir_o=2, SOP on the first and EOP+empty=3 on the last; first beat one cycle after ready rises.
- All 4 inputs hold a 2-beat packet from reset -> output order is dir 0,1,2,3 then 0 again. Exactly one idle cycle between packets; no interleaving.
- Input 1 sends 4 beats with ast_ready_i toggling 1,0,1,0 -> no beat lost or duplicated; output stable while ready=0; ast_ready_o[1]=0 during stall.
- Input 3 sends single-beat packets (SOP=EOP=1) back-to-back with input 0 also requesting -> grants alternate 3 then 0 (rr_ptr wraps from 3 to 0).
- Input 0 deasserts valid for 2 cycles mid-packet while input 1 is valid -> input 1 is not granted until input 0 EOP is accepted.
- rst_n_i pulsed low asynchronously (not on a clock edge) mid-packet -> all outputs 0 immediately. After release, a new packet from input 2 is served with ast_dir_o=2.
